unary_stream_encoder: RTL and testbench

//   Binary-to-unary converter: latches a WIDTH-bit value and emits it as a 1-bit

---
 rtl/unary_stream_encoder.sv | 126 ++++++++++++
 tb/tb_unary_stream_encoder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/unary_stream_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : unary_stream_encoder
//  Description : Binary-to-unary converter. Latches a WIDTH-bit value and
//                emits it as a 1-bit stream over a frame of 2^WIDTH cycles
//                containing exactly `value` ones. MODE 0 emits ones first
//                (thermometer); MODE 1 compares against the bit-reversed
//                frame counter for a low-discrepancy spread of the ones.
//  Revision    : 1.0 - initial release
// ============================================================================
module unary_stream_encoder #(
  parameter int WIDTH = 7,
  parameter int MODE  = 0
) (
  input  logic             clock,
  input  logic             reset,        // asynchronous, active-low
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [WIDTH-1:0] io_in_bits,
  output logic             io_out,
  output logic             io_out_valid,
  output logic             io_out_last,
  output logic             io_busy
);

  // Final frame index, N-1 (all ones over WIDTH bits).
  localparam logic [WIDTH-1:0] c_last = '1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] r_val;
  logic [WIDTH-1:0] w_val_nxt;

  logic w_running;
  logic w_at_last;
  logic w_accept;
  logic w_cmp;

  assign w_running = (r_state == ST_RUN);
  assign w_at_last = w_running && (r_cnt == c_last);

  // Ready in idle, and on the final cycle of a frame so the next frame can
  // follow with no gap. Purely a decode of state; never looks at valid.
  assign io_in_ready = (r_state == ST_IDLE) || w_at_last;
  assign w_accept    = io_in_valid && io_in_ready;

  // State, counter and latched value registers; reset aborts any frame.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_val   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_val   <= w_val_nxt;
    end
  end

  // Next-state logic: start on accept, count through the frame, and either
  // chain straight into a new frame or drop back to idle at the last index.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_val_nxt   = r_val;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
          w_val_nxt   = io_in_bits;
        end
      end
      ST_RUN: begin
        if (r_cnt == c_last) begin
          w_cnt_nxt = '0;
          if (w_accept) begin
            w_state_nxt = ST_RUN;
            w_val_nxt   = io_in_bits;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Stream comparator. Bit reversal is a permutation of 0..N-1, so both
  // modes produce exactly r_val ones per frame.
  generate
    if (MODE == 1) begin : g_mode_lowdisc
      logic [WIDTH-1:0] w_rev;
      // Reverse the counter bits to spread the ones evenly over the frame.
      always_comb begin
        w_rev = '0;
        for (int i = 0; i < WIDTH; i++) begin
          w_rev[i] = r_cnt[WIDTH-1-i];
        end
      end
      assign w_cmp = (w_rev < r_val);
    end else begin : g_mode_thermo
      assign w_cmp = (r_cnt < r_val);
    end
  endgenerate

  // Outputs decode registered state only, so they carry no input-path glitches.
  assign io_out       = w_running && w_cmp;
  assign io_out_valid = w_running;
  assign io_busy      = w_running;
  assign io_out_last  = w_at_last;

endmodule
`default_nettype wire

// File: tb/tb_unary_stream_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_unary_stream_encoder
//  Description : Directed bench for unary_stream_encoder. One thermometer
//                (MODE 0) and one low-discrepancy (MODE 1) instance share
//                all inputs; their outputs are checked against
//                hand-derived per-cycle expectations and frame popcounts.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_unary_stream_encoder;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       io_in_valid = 1'b0;
  logic [6:0] io_in_bits = 7'd0;

  logic ready0, out0, valid0, last0, busy0;
  logic ready1, out1, valid1, last1, busy1;

  int n_cmp = 0;
  int n_bad = 0;

  unary_stream_encoder #(.WIDTH(7), .MODE(0)) u_dut_m0 (
    .clock        (clock),
    .reset        (reset),
    .io_in_valid  (io_in_valid),
    .io_in_ready  (ready0),
    .io_in_bits   (io_in_bits),
    .io_out       (out0),
    .io_out_valid (valid0),
    .io_out_last  (last0),
    .io_busy      (busy0)
  );

  unary_stream_encoder #(.WIDTH(7), .MODE(1)) u_dut_m1 (
    .clock        (clock),
    .reset        (reset),
    .io_in_valid  (io_in_valid),
    .io_in_ready  (ready1),
    .io_in_bits   (io_in_bits),
    .io_out       (out1),
    .io_out_valid (valid1),
    .io_out_last  (last1),
    .io_busy      (busy1)
  );

  always #5 clock = ~clock;

  // Status of both instances: {valid,busy,last,ready} for MODE0 then MODE1.
  function automatic logic [7:0] status();
    return {valid0, busy0, last0, ready0, valid1, busy1, last1, ready1};
  endfunction

  function automatic logic [6:0] rev7(input logic [6:0] x);
    logic [6:0] r;
    for (int b = 0; b < 7; b++) r[b] = x[6-b];
    return r;
  endfunction

  // Offer v at the next falling edge; encoder must be idle and ready.
  task automatic start(input logic [6:0] v, input string tag);
    @(negedge clock);
    n_cmp++;
    if (status() !== 8'b0001_0001) begin
      n_bad++;
      $display("FAIL %s idle_status got=%b want=%b", tag, status(), 8'b0001_0001);
    end
    io_in_valid = 1'b1;
    io_in_bits  = v;
  endtask

  // Observe one full frame of value v. Optionally chain value nv at the last
  // cycle and scribble over io_in_bits while the frame runs.
  task automatic collect_frame(input logic [6:0] v, input bit chain,
                               input logic [6:0] nv, input bit toggle,
                               input string tag);
    int p0 = 0;
    int p1 = 0;
    logic       el;
    logic       e0;
    logic       e1;
    logic [7:0] es;
    for (int i = 0; i < 128; i++) begin
      @(negedge clock);
      if (i == 0) io_in_valid = 1'b0;
      if (toggle) io_in_bits = 7'($urandom);
      el = (i == 127);
      e0 = (i < int'(v));
      e1 = (rev7(7'(i)) < v);
      es = {1'b1, 1'b1, el, el, 1'b1, 1'b1, el, el};
      n_cmp++;
      if (status() !== es) begin
        n_bad++;
        $display("FAIL %s status cyc=%0d got=%b want=%b", tag, i, status(), es);
      end
      n_cmp++;
      if (out0 !== e0) begin
        n_bad++;
        $display("FAIL %s out_m0 cyc=%0d v=%0d got=%b want=%b", tag, i, v, out0, e0);
      end
      n_cmp++;
      if (out1 !== e1) begin
        n_bad++;
        $display("FAIL %s out_m1 cyc=%0d v=%0d got=%b want=%b", tag, i, v, out1, e1);
      end
      p0 += int'(out0);
      p1 += int'(out1);
      if (i == 127 && chain) begin
        io_in_valid = 1'b1;
        io_in_bits  = nv;
      end
    end
    n_cmp++;
    if (p0 != int'(v)) begin
      n_bad++;
      $display("FAIL %s popcount_m0 got=%0d want=%0d", tag, p0, v);
    end
    n_cmp++;
    if (p1 != int'(v)) begin
      n_bad++;
      $display("FAIL %s popcount_m1 got=%0d want=%0d", tag, p1, v);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    @(negedge clock);
    n_cmp++;
    if ({valid0, busy0, last0, out0, valid1, busy1, last1, out1} !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_outputs got=%b want=%b",
               {valid0, busy0, last0, out0, valid1, busy1, last1, out1}, 8'h00);
    end
    reset = 1'b1;
    @(negedge clock);
    n_cmp++;
    if (status() !== 8'b0001_0001) begin
      n_bad++;
      $display("FAIL reset_release got=%b want=%b", status(), 8'b0001_0001);
    end
  endtask

  task automatic test_zero();
    start(7'd0, "zero");
    collect_frame(7'd0, 1'b0, 7'd0, 1'b0, "zero");
  endtask

  task automatic test_half();
    start(7'd64, "half");
    collect_frame(7'd64, 1'b0, 7'd0, 1'b0, "half");
  endtask

  task automatic test_max();
    start(7'd127, "max");
    collect_frame(7'd127, 1'b0, 7'd0, 1'b0, "max");
  endtask

  task automatic test_back_to_back();
    start(7'd10, "b2b");
    collect_frame(7'd10, 1'b1, 7'd100, 1'b0, "b2b_a");
    collect_frame(7'd100, 1'b0, 7'd0, 1'b0, "b2b_b");
  endtask

  task automatic test_reset_mid();
    start(7'd20, "rstmid");
    for (int i = 0; i <= 50; i++) begin
      @(negedge clock);
      if (i == 0) io_in_valid = 1'b0;
    end
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if ({valid0, busy0, last0, out0, valid1, busy1, last1, out1} !== 8'h00) begin
      n_bad++;
      $display("FAIL rstmid_async got=%b want=%b",
               {valid0, busy0, last0, out0, valid1, busy1, last1, out1}, 8'h00);
    end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    start(7'd5, "rstmid_new");
    collect_frame(7'd5, 1'b0, 7'd0, 1'b0, "rstmid_new");
  endtask

  task automatic test_random();
    logic [6:0] v;
    logic [6:0] nv;
    bit         ch;
    v = 7'($urandom);
    start(v, "rand");
    for (int f = 0; f < 200; f++) begin
      nv = 7'($urandom);
      ch = ($urandom_range(0, 1) == 1) && (f < 199);
      collect_frame(v, ch, nv, 1'b1, "rand");
      v = nv;
      if (!ch && f < 199) start(v, "rand");
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_zero();
    test_half();
    test_max();
    test_back_to_back();
    test_reset_mid();
    test_random();
    @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
